coord_gen_cfg: RTL and testbench
================================

Name: coord_gen_cfg

Overview:
Parametrised successor to the fixed 640x480 pixel-coordinate generator feeding the fractal compute pipeline on out_stream_aclk. It emits one complex-plane sample per handshake as fixed-point c_re/c_im, alongside integer pixel indices and frame/line markers. Resolution is set by parameter; origin and step are runtime-programmable through shadow registers that apply only at frame boundaries. It supports continuous or single-frame operation.

Parameters:
X_SIZE, 640, pixels per line (>=2)
Y_SIZE, 480, lines per frame (>=2)
COORD_W, 32, width of c_re/c_im/step, two's complement, Q(COORD_W-FRAC_W).FRAC_W
FRAC_W, 28, fractional bits
XW, 10, pixel-x index width (2^XW >= X_SIZE)
YW, 9, pixel-y index width (2^YW >= Y_SIZE)
DEF_RE0, -536870912, reset top-left real (-2.0 in Q4.28)
DEF_IM0, 301989888, reset top-left imag (+1.125)
DEF_STEP, 1258291, reset per-pixel step (~3/640)

Ports:
out_stream_aclk  in  1  clock
periph_reset  in  1  asynchronous, active-high reset
enable  in  1  run request; level-sensitive
single_shot  in  1  1: stop after one frame; 0: continuous; sampled at frame start
cfg_wr  in  1  one-cycle strobe that writes the pending config
cfg_re0  in  COORD_W  pending top-left real
cfg_im0  in  COORD_W  pending top-left imag
cfg_step  in  COORD_W  pending step, unsigned magnitude
ready  in  1  downstream accept
valid  out  1  sample valid
c_re  out  COORD_W  real coordinate
c_im  out  COORD_W  imag coordinate
pix_x  out  XW  column index, 0 at left
pix_y  out  YW  row index, 0 at top
first_pixel  out  1  pix_x==0 && pix_y==0 && valid
last_re  out  1  pix_x==X_SIZE-1 && valid
last_pixel  out  1  last_re && pix_y==Y_SIZE-1
busy  out  1  state==RUN
cfg_pending  out  1  pending config not yet applied

Behaviour:
- Reset, asynchronous: state=IDLE; valid=0; pix_x=0; pix_y=0; c_re=0; c_im=0; active and pending config = DEF_*; cfg_pending=0. All other outputs are derived and therefore 0.
- States: IDLE, RUN.
- IDLE -> RUN when enable=1. In the same edge: active config <= pending (if cfg_pending, then cfg_pending<=0); c_re<=re0; c_im<=im0; pix_x=pix_y=0; single_shot latched; valid<=1. The first sample is therefore visible 1 cycle after enable is sampled high.
- In RUN, a beat is accepted on valid&&ready. Outputs hold stable while valid&&!ready (stream rule).
- Accepted beat, not last_re: pix_x+1; c_re+=step.
- Accepted last_re, not last_pixel: pix_x=0; pix_y+1; c_re=re0; c_im-=step.
- Accepted last_pixel:
  - if latched single_shot=1 or enable=0: state->IDLE, valid<=0.
  - else start a new frame with the same action as IDLE->RUN, with no bubble cycle.
- enable deasserted mid-frame does not abort; the frame completes.
- cfg_wr: pending<=cfg_* and cfg_pending<=1 on any cycle. It never alters the active config mid-frame.
- cfg_wr coincident with a frame-start edge: the new frame uses the previous pending values; the new write stays pending (cfg_pending=1).
- Arithmetic: c_re/c_im are updated incrementally (no multiplier) and wrap modulo 2^COORD_W; no saturation. The first pixel of each line equals re0 exactly, so there is no accumulated drift across lines.
- Coordinates are exact: c_re = re0 + pix_x*step; c_im = im0 - pix_y*step (mod 2^COORD_W).

Test Plan:
- X_SIZE=4, Y_SIZE=3, step=1, re0=0, im0=0; enable=1, ready=1 -> 12 beats; pix order (0,0)..(3,2); c_im 0,-1,-2 per row; first_pixel on beat 0; last_re on beats 3,7,11; last_pixel on beat 11; beat 12 is (0,0) with no gap.
- Same setup with ready toggling 1,0,0,1 -> outputs held constant while ready=0; no pixel skipped or repeated; 12 accepted beats per frame.
- single_shot=1, enable held -> exactly 12 beats, then valid=0 and busy=0 in the cycle after the last_pixel accept.
- cfg_wr mid-frame 1 with re0=100, step=2 -> frame 1 unchanged; cfg_pending=1; frame 2 starts c_re=100 and ends line at 106; cfg_pending=0 from frame-2 start.
- Assert periph_reset mid-line -> valid=0, pix_x=0, pix_y=0 immediately (asynchronously); after release with enable=1, a DEF_* frame starts with c_re=-536870912.
- re0=0x7FFFFFFE, step=1, X_SIZE=4 -> c_re sequence 0x7FFFFFFE, 0x7FFFFFFF, 0x80000000, 0x80000001 (wrap, no saturation).

Source files
------------

// File: rtl/coord_gen_cfg.sv
// Pixel/complex-plane coordinate generator with frame-boundary config shadowing.
// Emits one fixed-point sample per valid/ready beat, raster order.
module coord_gen_cfg #(
   parameter int X_SIZE  = 640,
   parameter int Y_SIZE  = 480,
   parameter int COORD_W = 32,
   parameter int FRAC_W  = 28,
   parameter int XW      = 10,
   parameter int YW      = 9,
   parameter logic [COORD_W-1:0] DEF_RE0  = COORD_W'(-536870912),
   parameter logic [COORD_W-1:0] DEF_IM0  = COORD_W'(301989888),
   parameter logic [COORD_W-1:0] DEF_STEP = COORD_W'(1258291)
) (
   input  logic               out_stream_aclk,
   input  logic               periph_reset,
   input  logic               enable,
   input  logic               single_shot,
   input  logic               cfg_wr,
   input  logic [COORD_W-1:0] cfg_re0,
   input  logic [COORD_W-1:0] cfg_im0,
   input  logic [COORD_W-1:0] cfg_step,
   input  logic               ready,
   output logic               valid,
   output logic [COORD_W-1:0] c_re,
   output logic [COORD_W-1:0] c_im,
   output logic [XW-1:0]      pix_x,
   output logic [YW-1:0]      pix_y,
   output logic               first_pixel,
   output logic               last_re,
   output logic               last_pixel,
   output logic               busy,
   output logic               cfg_pending
);

   localparam logic [XW-1:0] X_LAST = XW'(X_SIZE - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(Y_SIZE - 1);

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t             r_state;
   state_t             w_nstate;
   logic               r_valid;
   logic [COORD_W-1:0] r_c_re;
   logic [COORD_W-1:0] r_c_im;
   logic [XW-1:0]      r_pix_x;
   logic [YW-1:0]      r_pix_y;
   logic               r_single;
   logic [COORD_W-1:0] r_re0;
   logic [COORD_W-1:0] r_step;
   logic [COORD_W-1:0] r_p_re0;
   logic [COORD_W-1:0] r_p_im0;
   logic [COORD_W-1:0] r_p_step;
   logic               r_pending;

   logic w_accept;
   logic w_last_re;
   logic w_last_pix;
   logic w_start;
   logic w_stop;

   assign w_accept   = r_valid & ready;
   assign w_last_re  = r_valid && (r_pix_x == X_LAST);
   assign w_last_pix = w_last_re && (r_pix_y == Y_LAST);

   always_ff @(posedge out_stream_aclk or posedge periph_reset) begin
      if (periph_reset) r_state <= S_IDLE;
      else              r_state <= w_nstate;
   end

   // Frame start reuses the same path from IDLE and back-to-back from RUN.
   always_comb begin
      w_nstate = r_state;
      w_start  = 1'b0;
      w_stop   = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (enable) begin
               w_nstate = S_RUN;
               w_start  = 1'b1;
            end
         end
         S_RUN: begin
            if (w_accept && w_last_pix) begin
               if (r_single || !enable) begin
                  w_nstate = S_IDLE;
                  w_stop   = 1'b1;
               end else begin
                  w_start = 1'b1;
               end
            end
         end
         default: w_nstate = S_IDLE;
      endcase
   end

   always_ff @(posedge out_stream_aclk or posedge periph_reset) begin
      if (periph_reset) begin
         r_valid   <= 1'b0;
         r_c_re    <= '0;
         r_c_im    <= '0;
         r_pix_x   <= '0;
         r_pix_y   <= '0;
         r_single  <= 1'b0;
         r_re0     <= DEF_RE0;
         r_step    <= DEF_STEP;
         r_p_re0   <= DEF_RE0;
         r_p_im0   <= DEF_IM0;
         r_p_step  <= DEF_STEP;
         r_pending <= 1'b0;
      end else begin
         if (w_start) begin
            r_re0    <= r_p_re0;
            r_step   <= r_p_step;
            r_c_re   <= r_p_re0;
            r_c_im   <= r_p_im0;
            r_pix_x  <= '0;
            r_pix_y  <= '0;
            r_single <= single_shot;
            r_valid  <= 1'b1;
         end else if (w_stop) begin
            r_valid <= 1'b0;
         end else if (w_accept) begin
            if (w_last_re) begin
               r_pix_x <= '0;
               r_pix_y <= r_pix_y + 1'b1;
               r_c_re  <= r_re0;
               r_c_im  <= r_c_im - r_step;
            end else begin
               r_pix_x <= r_pix_x + 1'b1;
               r_c_re  <= r_c_re + r_step;
            end
         end
         // A write racing a frame start stays pending for the next frame.
         if (cfg_wr) begin
            r_p_re0   <= cfg_re0;
            r_p_im0   <= cfg_im0;
            r_p_step  <= cfg_step;
            r_pending <= 1'b1;
         end else if (w_start) begin
            r_pending <= 1'b0;
         end
      end
   end

   assign valid       = r_valid;
   assign c_re        = r_c_re;
   assign c_im        = r_c_im;
   assign pix_x       = r_pix_x;
   assign pix_y       = r_pix_y;
   assign first_pixel = r_valid && (r_pix_x == '0) && (r_pix_y == '0);
   assign last_re     = w_last_re;
   assign last_pixel  = w_last_pix;
   assign busy        = (r_state == S_RUN);
   assign cfg_pending = r_pending;

endmodule

// File: tb/tb_coord_gen_cfg.sv
// Directed bench for coord_gen_cfg at 4x3 resolution.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_coord_gen_cfg;

   localparam int XS = 4;
   localparam int YS = 3;
   localparam logic [31:0] D_RE0  = 32'hE000_0000;
   localparam logic [31:0] D_IM0  = 32'd301989888;
   localparam logic [31:0] D_STEP = 32'd1258291;

   logic        clk = 1'b0;
   logic        rst;
   logic        enable;
   logic        single_shot;
   logic        cfg_wr;
   logic [31:0] cfg_re0;
   logic [31:0] cfg_im0;
   logic [31:0] cfg_step;
   logic        ready;
   logic        valid;
   logic [31:0] c_re;
   logic [31:0] c_im;
   logic [1:0]  pix_x;
   logic [1:0]  pix_y;
   logic        first_pixel;
   logic        last_re;
   logic        last_pixel;
   logic        busy;
   logic        cfg_pending;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   coord_gen_cfg #(
      .X_SIZE(XS), .Y_SIZE(YS), .COORD_W(32), .FRAC_W(28),
      .XW(2), .YW(2)
   ) dut (
      .out_stream_aclk(clk),
      .periph_reset(rst),
      .enable(enable),
      .single_shot(single_shot),
      .cfg_wr(cfg_wr),
      .cfg_re0(cfg_re0),
      .cfg_im0(cfg_im0),
      .cfg_step(cfg_step),
      .ready(ready),
      .valid(valid),
      .c_re(c_re),
      .c_im(c_im),
      .pix_x(pix_x),
      .pix_y(pix_y),
      .first_pixel(first_pixel),
      .last_re(last_re),
      .last_pixel(last_pixel),
      .busy(busy),
      .cfg_pending(cfg_pending)
   );

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic cfg(input logic [31:0] re0, input logic [31:0] im0,
                      input logic [31:0] st);
      cfg_wr   = 1'b1;
      cfg_re0  = re0;
      cfg_im0  = im0;
      cfg_step = st;
      @(negedge clk);
      cfg_wr = 1'b0;
   endtask

   // Checks n accepted beats starting at raster index b0.
   task automatic run(input int n, input logic [31:0] re0,
                      input logic [31:0] im0, input logic [31:0] st,
                      input bit tog, input int b0);
      bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      int b = b0;
      int acc = 0;
      int cyc = 0;
      int ex, ey;
      logic [31:0] e_re, e_im;
      while (acc < n && cyc < 200) begin
         ex   = b % XS;
         ey   = (b / XS) % YS;
         e_re = re0 + 32'(ex) * st;
         e_im = im0 - 32'(ey) * st;
         chk("valid", 64'(valid), 64'd1);
         chk("pix_x", 64'(pix_x), 64'(ex));
         chk("pix_y", 64'(pix_y), 64'(ey));
         chk("c_re", 64'(c_re), 64'(e_re));
         chk("c_im", 64'(c_im), 64'(e_im));
         chk("first", 64'(first_pixel), 64'(ex == 0 && ey == 0));
         chk("last_re", 64'(last_re), 64'(ex == XS - 1));
         chk("last_pix", 64'(last_pixel),
             64'(ex == XS - 1 && ey == YS - 1));
         ready = tog ? pat[cyc % 4] : 1'b1;
         if (ready) begin
            acc++;
            b++;
         end
         @(negedge clk);
         cyc++;
      end
      if (acc < n) chk("timeout", 64'(acc), 64'(n));
      ready = 1'b1;
   endtask

   initial begin
      rst = 1'b1; enable = 1'b0; single_shot = 1'b0; cfg_wr = 1'b0;
      cfg_re0 = '0; cfg_im0 = '0; cfg_step = '0; ready = 1'b0;
      @(negedge clk);
      chk("rst_valid", 64'(valid), 64'd0);
      chk("rst_px", 64'(pix_x), 64'd0);
      chk("rst_py", 64'(pix_y), 64'd0);
      chk("rst_re", 64'(c_re), 64'd0);
      chk("rst_im", 64'(c_im), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_pend", 64'(cfg_pending), 64'd0);
      chk("rst_first", 64'(first_pixel), 64'd0);
      rst = 1'b0;
      @(negedge clk);
      cfg(32'd0, 32'd0, 32'd1);
      chk("pend_set", 64'(cfg_pending), 64'd1);
      enable = 1'b1;
      ready  = 1'b1;
      @(negedge clk);
      chk("pend_clr", 64'(cfg_pending), 64'd0);
      chk("busy_run", 64'(busy), 64'd1);
      // full frame plus the gapless first beat of the next
      run(13, 32'd0, 32'd0, 32'd1, 1'b0, 0);
      // backpressure 1,0,0,1
      run(24, 32'd0, 32'd0, 32'd1, 1'b1, 13);
      // enable dropped mid-frame: frame completes, then idle
      enable = 1'b0;
      run(11, 32'd0, 32'd0, 32'd1, 1'b0, 37);
      chk("stop_valid", 64'(valid), 64'd0);
      chk("stop_busy", 64'(busy), 64'd0);
      // single shot
      single_shot = 1'b1;
      enable      = 1'b1;
      @(negedge clk);
      run(12, 32'd0, 32'd0, 32'd1, 1'b0, 0);
      chk("ss_valid", 64'(valid), 64'd0);
      chk("ss_busy", 64'(busy), 64'd0);
      enable      = 1'b0;
      single_shot = 1'b0;
      @(negedge clk);
      chk("idle_valid", 64'(valid), 64'd0);
      // config written mid-frame applies at next frame
      enable = 1'b1;
      @(negedge clk);
      run(5, 32'd0, 32'd0, 32'd1, 1'b0, 0);
      cfg(32'd100, 32'd0, 32'd2);
      chk("mid_pend", 64'(cfg_pending), 64'd1);
      run(6, 32'd0, 32'd0, 32'd1, 1'b0, 6);
      chk("f2_pend", 64'(cfg_pending), 64'd0);
      chk("f2_re", 64'(c_re), 64'd100);
      run(3, 32'd100, 32'd0, 32'd2, 1'b0, 0);
      chk("f2_eol", 64'(c_re), 64'd106);
      chk("f2_lre", 64'(last_re), 64'd1);
      run(8, 32'd100, 32'd0, 32'd2, 1'b0, 3);
      // write coincident with frame start stays pending
      chk("f2_lpix", 64'(last_pixel), 64'd1);
      cfg(32'd7, 32'd0, 32'd1);
      chk("co_re", 64'(c_re), 64'd100);
      chk("co_pend", 64'(cfg_pending), 64'd1);
      // asynchronous reset mid-line
      run(2, 32'd100, 32'd0, 32'd2, 1'b0, 0);
      #2 rst = 1'b1;
      #1;
      chk("ar_valid", 64'(valid), 64'd0);
      chk("ar_px", 64'(pix_x), 64'd0);
      chk("ar_py", 64'(pix_y), 64'd0);
      chk("ar_busy", 64'(busy), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("def_re", 64'(c_re), 64'(D_RE0));
      chk("def_pend", 64'(cfg_pending), 64'd0);
      run(5, D_RE0, D_IM0, D_STEP, 1'b0, 0);
      enable = 1'b0;
      run(7, D_RE0, D_IM0, D_STEP, 1'b0, 5);
      chk("def_idle", 64'(valid), 64'd0);
      // wrap without saturation
      cfg(32'h7FFF_FFFE, 32'd0, 32'd1);
      enable = 1'b1;
      @(negedge clk);
      run(4, 32'h7FFF_FFFE, 32'd0, 32'd1, 1'b0, 0);
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
